// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with up/down stepping, checked parallel load,
// registered wrap/error pulses and combinational range-end flags.
module bcd_mod_counter #(
  parameter int MAX_VAL   = 23,
  parameter int MIN_VAL   = 0,
  parameter int RESET_VAL = MIN_VAL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       set,
  input  logic [3:0] new_tens,
  input  logic [3:0] new_units,
  output logic [3:0] tens_q,
  output logic [3:0] units_q,
  output logic       carry,
  output logic       borrow,
  output logic       at_max,
  output logic       at_min,
  output logic       set_err
);

  localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_U = 4'(MAX_VAL % 10);
  localparam logic [3:0] MIN_T = 4'(MIN_VAL / 10);
  localparam logic [3:0] MIN_U = 4'(MIN_VAL % 10);
  localparam logic [3:0] RST_T = 4'(RESET_VAL / 10);
  localparam logic [3:0] RST_U = 4'(RESET_VAL % 10);
  localparam logic [6:0] MAX_B = 7'(MAX_VAL);
  localparam logic [6:0] MIN_B = 7'(MIN_VAL);

  logic       digits_ok;
  logic [6:0] set_bin;
  logic       set_ok;

  assign at_max = (tens_q == MAX_T) && (units_q == MAX_U);
  assign at_min = (tens_q == MIN_T) && (units_q == MIN_U);

  // Binary value of the load digits is only meaningful once both are BCD-legal.
  assign digits_ok = (new_tens <= 4'd9) && (new_units <= 4'd9);
  assign set_bin   = {3'b000, new_tens} * 7'd10 + {3'b000, new_units};
  assign set_ok    = digits_ok && (set_bin >= MIN_B) && (set_bin <= MAX_B);

  // NOTE: non-blocking assignments keep every register reading the pre-edge
  // count, so the wrap decisions and the pulses all see the same state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens_q  <= RST_T;
      units_q <= RST_U;
      carry   <= 1'b0;
      borrow  <= 1'b0;
      set_err <= 1'b0;
    end else begin
      carry   <= 1'b0;
      borrow  <= 1'b0;
      set_err <= 1'b0;
      if (set) begin
        if (set_ok) begin
          tens_q  <= new_tens;
          units_q <= new_units;
        end else begin
          set_err <= 1'b1;
        end
      end else if (inc && !dec) begin
        if (at_max) begin
          tens_q  <= MIN_T;
          units_q <= MIN_U;
          carry   <= 1'b1;
        end else if (units_q == 4'd9) begin
          tens_q  <= tens_q + 4'd1;
          units_q <= 4'd0;
        end else begin
          units_q <= units_q + 4'd1;
        end
      end else if (dec && !inc) begin
        if (at_min) begin
          tens_q  <= MAX_T;
          units_q <= MAX_U;
          borrow  <= 1'b1;
        end else if (units_q == 4'd0) begin
          tens_q  <= tens_q - 4'd1;
          units_q <= 4'd9;
        end else begin
          units_q <= units_q - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: three instances (23/0, 12/1/12, 59/0)
// driven by directed steps, expectations queued with the stimulus.
module tb_bcd_mod_counter;

  logic            clk = 1'b0;
  logic [2:0]      reset, inc, dec, set;
  logic [2:0][3:0] new_tens, new_units, tens_q, units_q;
  logic [2:0]      carry, borrow, at_max, at_min, set_err;

  typedef struct {
    string       tag;
    int          dut;
    logic [12:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bcd_mod_counter u_h23 (
    .clk(clk), .reset(reset[0]), .inc(inc[0]), .dec(dec[0]), .set(set[0]),
    .new_tens(new_tens[0]), .new_units(new_units[0]), .tens_q(tens_q[0]),
    .units_q(units_q[0]), .carry(carry[0]), .borrow(borrow[0]),
    .at_max(at_max[0]), .at_min(at_min[0]), .set_err(set_err[0]));

  bcd_mod_counter #(.MAX_VAL(12), .MIN_VAL(1), .RESET_VAL(12)) u_h12 (
    .clk(clk), .reset(reset[1]), .inc(inc[1]), .dec(dec[1]), .set(set[1]),
    .new_tens(new_tens[1]), .new_units(new_units[1]), .tens_q(tens_q[1]),
    .units_q(units_q[1]), .carry(carry[1]), .borrow(borrow[1]),
    .at_max(at_max[1]), .at_min(at_min[1]), .set_err(set_err[1]));

  bcd_mod_counter #(.MAX_VAL(59)) u_m59 (
    .clk(clk), .reset(reset[2]), .inc(inc[2]), .dec(dec[2]), .set(set[2]),
    .new_tens(new_tens[2]), .new_units(new_units[2]), .tens_q(tens_q[2]),
    .units_q(units_q[2]), .carry(carry[2]), .borrow(borrow[2]),
    .at_max(at_max[2]), .at_min(at_min[2]), .set_err(set_err[2]));

  // Expected word layout: {tens, units, carry, borrow, set_err, at_max, at_min}
  function automatic logic [12:0] mk(input logic [3:0] t, input logic [3:0] u,
                                     input logic c, input logic b, input logic e,
                                     input logic mx, input logic mn);
    return {t, u, c, b, e, mx, mn};
  endfunction

  function automatic logic [12:0] obs(input int d);
    return {tens_q[d], units_q[d], carry[d], borrow[d], set_err[d], at_max[d], at_min[d]};
  endfunction

  task automatic push(input string tag, input int d, input logic [12:0] v);
    exp_t e;
    e.tag = tag;
    e.dut = d;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      assert (obs(e.dut) === e.val)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs(e.dut), e.val);
      end
    end
  endtask

  task automatic drive(input int d, input logic i, input logic dd, input logic s,
                       input logic [3:0] t, input logic [3:0] u);
    inc[d]       = i;
    dec[d]       = dd;
    set[d]       = s;
    new_tens[d]  = t;
    new_units[d] = u;
  endtask

  // One clocked step: drive, queue the expected result, sample #1 after the edge.
  task automatic step(input string tag, input int d, input logic i, input logic dd,
                      input logic s, input logic [3:0] t, input logic [3:0] u,
                      input logic [12:0] v);
    drive(d, i, dd, s, t, u);
    push(tag, d, v);
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: run did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    reset = 3'b111;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    // Inputs presented during reset must be ignored.
    drive(0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    drive(2, 1'b0, 1'b0, 1'b1, 4'd4, 4'd5);
    #2;
    push("rst_h23", 0, mk(4'd0, 4'd0, 0, 0, 0, 0, 1));
    push("rst_h12", 1, mk(4'd1, 4'd2, 0, 0, 0, 1, 0));
    push("rst_m59", 2, mk(4'd0, 4'd0, 0, 0, 0, 0, 1));
    drain();
    @(posedge clk);
    #1;
    push("rst_hold_h23", 0, mk(4'd0, 4'd0, 0, 0, 0, 0, 1));
    push("rst_hold_m59", 2, mk(4'd0, 4'd0, 0, 0, 0, 0, 1));
    drain();
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    reset = 3'b000;

    // 23/0: full up-sweep through the wrap.
    for (int k = 1; k <= 24; k++) begin
      v = k % 24;
      step($sformatf("inc_sweep_%0d", k), 0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,
           mk(4'(v / 10), 4'(v % 10), k == 24, 1'b0, 1'b0, v == 23, v == 0));
    end
    step("carry_drop",   0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(4'd0, 4'd0, 0, 0, 0, 0, 1));
    step("inc_dec_hold", 0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, mk(4'd0, 4'd0, 0, 0, 0, 0, 1));
    step("dec_wrap",     0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, mk(4'd2, 4'd3, 0, 1, 0, 1, 0));
    step("dec_22",       0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, mk(4'd2, 4'd2, 0, 0, 0, 0, 0));
    step("inc_23",       0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, mk(4'd2, 4'd3, 0, 0, 0, 1, 0));
    step("inc_wrap",     0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, mk(4'd0, 4'd0, 1, 0, 0, 0, 1));
    drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    reset[0] = 1'b1;
    #1;
    push("mid_rst_h23", 0, mk(4'd0, 4'd0, 0, 0, 0, 0, 1));
    drain();
    #1;
    reset[0] = 1'b0;

    // 12/1 with reset value 12.
    step("h12_inc_wrap", 1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, mk(4'd0, 4'd1, 1, 0, 0, 0, 1));
    step("h12_idle",     1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(4'd0, 4'd1, 0, 0, 0, 0, 1));
    step("h12_dec_wrap", 1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, mk(4'd1, 4'd2, 0, 1, 0, 1, 0));
    step("h12_idle2",    1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(4'd1, 4'd2, 0, 0, 0, 1, 0));
    step("h12_inc_wrap2",1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, mk(4'd0, 4'd1, 1, 0, 0, 0, 1));
    drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    reset[1] = 1'b1;
    #1;
    push("mid_rst_h12", 1, mk(4'd1, 4'd2, 0, 0, 0, 1, 0));
    drain();
    #1;
    reset[1] = 1'b0;

    // 59/0: loads, rejected loads, digit wraps.
    step("set_45",       2, 1'b0, 1'b0, 1'b1, 4'd4, 4'd5,   mk(4'd4, 4'd5, 0, 0, 0, 0, 0));
    step("set_60_rej",   2, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0,   mk(4'd4, 4'd5, 0, 0, 1, 0, 0));
    step("set_0A_rej",   2, 1'b0, 1'b0, 1'b1, 4'd0, 4'hA,   mk(4'd4, 4'd5, 0, 0, 1, 0, 0));
    step("err_drop",     2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,   mk(4'd4, 4'd5, 0, 0, 0, 0, 0));
    step("set_59_dec",   2, 1'b0, 1'b1, 1'b1, 4'd5, 4'd9,   mk(4'd5, 4'd9, 0, 0, 0, 1, 0));
    step("set_15_inc",   2, 1'b1, 1'b0, 1'b1, 4'd1, 4'd5,   mk(4'd1, 4'd5, 0, 0, 0, 0, 0));
    step("inc_16",       2, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,   mk(4'd1, 4'd6, 0, 0, 0, 0, 0));
    step("set_39",       2, 1'b0, 1'b0, 1'b1, 4'd3, 4'd9,   mk(4'd3, 4'd9, 0, 0, 0, 0, 0));
    step("inc_40",       2, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,   mk(4'd4, 4'd0, 0, 0, 0, 0, 0));
    step("dec_39",       2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0,   mk(4'd3, 4'd9, 0, 0, 0, 0, 0));
    step("both_39",      2, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0,   mk(4'd3, 4'd9, 0, 0, 0, 0, 0));
    step("set_70_inc",   2, 1'b1, 1'b0, 1'b1, 4'd7, 4'd0,   mk(4'd3, 4'd9, 0, 0, 1, 0, 0));
    step("set_00",       2, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0,   mk(4'd0, 4'd0, 0, 0, 0, 0, 1));
    step("m59_dec_wrap", 2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0,   mk(4'd5, 4'd9, 0, 1, 0, 1, 0));
    step("m59_idle",     2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,   mk(4'd5, 4'd9, 0, 0, 0, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 SHALL have parameter MAX_VAL, default 23: highest count (decimal, 1..99); set to 59 for minutes/seconds and 12 for 12-hour hours.
REQ-002 SHALL have parameter MIN_VAL, default 0: lowest count (0 or 1), with MIN_VAL < MAX_VAL.
REQ-003 SHALL have parameter RESET_VAL, default MIN_VAL: count loaded on reset, with MIN_VAL <= RESET_VAL <= MAX_VAL.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port inc  input  1: count-up request, sampled each cycle.
REQ-007 SHALL have port dec  input  1: count-down request, sampled each cycle.
REQ-008 SHALL have port set  input  1: load request for new_tens/new_units.
REQ-009 SHALL have port new_tens  input  4: BCD tens digit to load.
REQ-010 SHALL have port new_units  input  4: BCD units digit to load.
REQ-011 SHALL have port tens_q  output  4: current BCD tens digit.
REQ-012 SHALL have port units_q  output  4: current BCD units digit.
REQ-013 SHALL have port carry  output  1: registered one-cycle pulse on an up-wrap.
REQ-014 SHALL have port borrow  output  1: registered one-cycle pulse on a down-wrap.
REQ-015 SHALL have port at_max  output  1: combinational, high while the count equals MAX_VAL.
REQ-016 SHALL have port at_min  output  1: combinational, high while the count equals MIN_VAL.
REQ-017 SHALL have port set_err  output  1: registered one-cycle pulse when a set is rejected.

Function
REQ-018 SHALL hold the count as two BCD digits only; units_q and tens_q SHALL never exceed 9, and the count SHALL never leave [MIN_VAL, MAX_VAL].
REQ-019 SHALL apply, at each rising edge, the priority: set, then inc xor dec, then hold.
REQ-020 SHALL treat inc and dec high together, with set low, as hold: count unchanged, carry and borrow low.
REQ-021 SHALL, on inc below MAX_VAL, add 1 to the count; units wrap 9->0 with tens+1 in the same cycle (e.g. 09 -> 10).
REQ-022 SHALL, on inc at MAX_VAL, load MIN_VAL and assert carry for exactly the next cycle.
REQ-023 SHALL, on dec above MIN_VAL, subtract 1 from the count; units wrap 0->9 with tens-1 in the same cycle (e.g. 10 -> 09).
REQ-024 SHALL, on dec at MIN_VAL, load MAX_VAL and assert borrow for exactly the next cycle.
REQ-025 SHALL accept a set only if both digits are <= 9 and 10*new_tens + new_units lies in [MIN_VAL, MAX_VAL]; the count then updates on that edge.
REQ-026 SHALL reject any other set: count unchanged, set_err high for exactly the next cycle.
REQ-027 SHALL ignore inc and dec in any cycle where set is high, whether the set is accepted or rejected.
REQ-028 SHALL never assert carry or borrow as a result of a set.
REQ-029 SHALL allow carry to stay high on consecutive cycles when inc is held and each cycle wraps (only possible for a one-value range).
REQ-030 SHALL keep carry, borrow and set_err mutually exclusive in any cycle.

Reset
REQ-031 SHALL, while reset is high, immediately force tens_q/units_q to the BCD digits of RESET_VAL and carry, borrow and set_err to 0, without waiting for clk.
REQ-032 SHALL ignore inc, dec and set while reset is high; the first edge after release acts on the inputs sampled at that edge.
REQ-033 SHALL cancel, when reset asserts mid-pulse, any pending carry, borrow or set_err pulse at once.

Verification
REQ-034 SHALL cover, with MAX_VAL=23, MIN_VAL=0: reset, then 24 inc pulses -> count steps 00..23 -> 00, carry high only in the cycle after 23->00, at_max high only at 23.
REQ-035 SHALL cover, with MAX_VAL=12, MIN_VAL=1, RESET_VAL=12: reset -> 12 with at_max=1; inc -> 01 with carry pulse; dec -> 12 with borrow pulse.
REQ-036 SHALL cover, with MAX_VAL=59: set 4/5 -> 45; set 6/0 -> count stays 45 with set_err pulse; set 0/10 (units 0xA) -> rejected with set_err pulse.
REQ-037 SHALL cover, with MAX_VAL=59 and count 39: inc -> 40; dec -> 39; inc and dec together -> 39 held with no pulses.
REQ-038 SHALL cover, with MAX_VAL=59 and count 59: set 1/5 with inc -> 15 and no carry; next cycle inc -> 16.
REQ-039 SHALL cover, with MAX_VAL=23 and count 23: inc, then reset asserted mid-cycle while carry is high -> count returns to RESET_VAL and carry drops immediately, both before the next clk edge.
